pooling_unit_n: RTL and testbench
=================================

# pooling_unit_n

Parametrised pooling engine and successor to the 1-bit average pooler. It reads multi-bit pixels of a square image from a synchronous read memory and reduces each non-overlapping n×n window to one output pixel, by either average or maximum. Results leave as a valid/ready stream in raster order. It sits between the frame buffer and the classifier input buffer.

## Interface
Parameters:
- in_width, 8: input pixel width in bits.
- out_width, 8: output pixel width in bits. Must satisfy out_width ≤ in_width.
- n, 4: window side. Power of two, ≥ 2.
- side, 112: input image side length. Must be a multiple of n.
- addr_width, $clog2(side*side): width of the input address.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; low freezes all state and outputs.
- start  in  1  begin one frame; sampled only in IDLE.
- mode  in  1  0 = average, 1 = max; latched at start.
- in_addr  out  addr_width  pixel read address.
- in_pixel  in  in_width  read data; valid one cycle after in_addr.
- out_pixel  out  out_width  pooled pixel.
- out_index  out  $clog2((side/n)**2)  raster index of out_pixel.
- out_valid  out  1  out_pixel and out_index are valid.
- out_ready  in  1  downstream accepts the output.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the frame completes.

## Operation
- States and transitions:
  - IDLE → FETCH on start=1 (with en=1).
  - FETCH → DRAIN after n² addresses have been issued.
  - DRAIN → EMIT.
  - EMIT → FETCH on handshake when more windows remain.
  - EMIT → DONE on handshake of the last window.
  - DONE → IDLE.
- Handshake: an output transfer happens when out_valid & out_ready & en.
- Window (oy, ox) with element (wy, wx): in_addr = (oy·n+wy)·side + ox·n + wx. Inner order is wx fastest, then wy. Windows are processed in raster order, ox fastest.
- A one-cycle-delayed sample flag qualifies in_pixel. The accumulator updates only on flagged cycles.
- Accumulator width is in_width + 2·log2(n); no overflow is possible.
  - Average: acc >> (2·log2 n), truncated, not rounded.
  - Max: running unsigned maximum; the first sample of a window replaces the value.
- Output scaling: out_pixel = result[in_width-1 -: out_width], i.e. the MSBs.
- The accumulator clears when a window's first sample is taken, so no residue carries between windows.
- mode is ignored after start; a change mid-frame has no effect.
- start is ignored outside IDLE.
- en=0 freezes everything:
  - in_addr holds, so in_pixel remains valid for the held address.
  - The sample flag holds.
  - out_valid and out_pixel hold and no transfer occurs.
  - A done pulse is stretched while en is low.
- reset_n low at any time forces immediate return to IDLE and aborts the frame; no done pulse is produced.

## Timing
- Reset values: in_addr=0, out_pixel=0, out_index=0, out_valid=0, busy=0, done=0.
- With en=1 and out_ready=1, the start edge is edge 0:
  - Addresses are issued in cycles 1..n².
  - Data is accumulated at edges 2..n²+1.
  - out_valid rises after edge n²+1.
- Each window takes n²+2 cycles with out_ready held high; extra cycles equal the stall cycles.
- Frame length is (side/n)²·(n²+2) + 2 cycles, start to done.
- done asserts the cycle after the last handshake; busy falls together with the done pulse.
- out_valid stays high until the handshake; out_pixel and out_index are stable while out_valid=1.

## Structure
- Shared package pooling_pkg:
  - state enum (IDLE, FETCH, DRAIN, EMIT, DONE)
  - MODE_AVG=0, MODE_MAX=1
  - a log2 helper function
- One natural sub-module, pool_window_addr_gen: nested wx/wy/ox/oy counters producing in_addr, last_in_window and last_window.
- Reduction, FSM and output register stay in the top.

## Test plan
Bench uses side=8, n=2, in_width=8, out_width=8, a 1-cycle-latency RAM model, and out_ready=1 unless stated.
- All pixels 0xFF, average → 16 outputs of 0xFF, out_index 0..15 in order; done after 16·6+2 = 98 cycles.
- Pixel = address (0..63), average → output k=(oy,ox): floor((4·(16oy+2ox)+18)/4); first value 0x04, last 0x3A.
- Same image, max → output 0 = 0x09, output 15 = 0x3F.
- Random out_ready (50%) → identical output sequence; out_pixel and out_index stable while out_valid=1 and out_ready=0.
- en held low for 5 cycles mid-FETCH → in_addr is frozen and the final outputs match the no-stall run; the same check applies with en held low during the done pulse.
- reset_n asserted mid-frame, then a new start → busy and out_valid fall immediately, no done pulse; the new frame completes correctly with out_width=4 giving the MSBs (0xFF → 0xF).

Source files
------------

// File: rtl/pooling_pkg.sv
// pooling_pkg: shared FSM state type, mode encodings and log2 helper for the pooling engine.
package pooling_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EMIT, DONE} state_t;
  localparam logic MODE_AVG = 1'b0;
  localparam logic MODE_MAX = 1'b1;
  function automatic int log2(input int v);
    return $clog2(v);
  endfunction
endpackage

// File: rtl/pooling_unit_n_if.sv
// pooling_unit_n_if: control, pixel-read and output-stream signals of the pooling engine.
// master = engine side (drives in_addr, out_*, busy, done); slave = environment side.
interface pooling_unit_n_if #(
  parameter int in_width   = 8,
  parameter int out_width  = 8,
  parameter int n          = 4,
  parameter int side       = 112,
  parameter int addr_width = $clog2(side*side)
);
  localparam int idx_width = $clog2((side/n)**2);
  logic                  en;
  logic                  start;
  logic                  mode;
  logic [addr_width-1:0] in_addr;
  logic [in_width-1:0]   in_pixel;
  logic [out_width-1:0]  out_pixel;
  logic [idx_width-1:0]  out_index;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  modport master (
    input  en, start, mode, in_pixel, out_ready,
    output in_addr, out_pixel, out_index, out_valid, busy, done
  );
  modport slave (
    output en, start, mode, in_pixel, out_ready,
    input  in_addr, out_pixel, out_index, out_valid, busy, done
  );
endinterface

// File: rtl/pool_window_addr_gen.sv
// pool_window_addr_gen: wx/wy/ox/oy counters producing the pixel read address and window position.
// Ports: step_i advances the in-window element, next_i advances to the next window;
// in_addr_o read address, win_index_o raster window index, last_* flags for the FSM.
module pool_window_addr_gen
  import pooling_pkg::*;
#(
  parameter int n          = 4,
  parameter int side       = 112,
  parameter int addr_width = $clog2(side*side),
  parameter int iw         = $clog2((side/n)**2)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  step_i,
  input  logic                  next_i,
  output logic [addr_width-1:0] in_addr_o,
  output logic [iw-1:0]         win_index_o,
  output logic                  last_in_window_o,
  output logic                  last_window_o
);
  localparam int ln = log2(n);
  localparam int nw = side / n;
  localparam int ow = nw > 1 ? $clog2(nw) : 1;
  logic [ln-1:0] wx_q, wy_q;
  logic [ow-1:0] ox_q, oy_q;
  logic          last_ox;
  assign last_ox          = ox_q == ow'(nw - 1);
  assign last_in_window_o = &{wx_q, wy_q};
  assign last_window_o    = last_ox && oy_q == ow'(nw - 1);
  assign in_addr_o   = addr_width'((int'(oy_q) * n + int'(wy_q)) * side + int'(ox_q) * n + int'(wx_q));
  assign win_index_o = iw'(int'(oy_q) * nw + int'(ox_q));
  // wx/wy wrap on their own (n is a power of two); ox/oy only move on the output
  // handshake so the window position stays valid as out_index during EMIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wx_q <= '0;
      wy_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      if (step_i) begin
        wx_q <= wx_q + ln'(1);
        wy_q <= &wx_q ? wy_q + ln'(1) : wy_q;
      end
      if (next_i) begin
        ox_q <= last_ox ? '0 : ox_q + ow'(1);
        oy_q <= !last_ox ? oy_q : last_window_o ? '0 : oy_q + ow'(1);
      end
    end
  end
endmodule

// File: rtl/pooling_unit_n.sv
// pooling_unit_n: reduces non-overlapping n x n windows of a side x side image to one pixel (avg or max).
// Ports: clk, reset_n (async active-low), bus (pooling_unit_n_if.master): en/start/mode control,
// in_addr/in_pixel synchronous memory read, out_pixel/out_index/out_valid/out_ready stream, busy/done.
module pooling_unit_n
  import pooling_pkg::*;
#(
  parameter int in_width   = 8,
  parameter int out_width  = 8,
  parameter int n          = 4,
  parameter int side       = 112,
  parameter int addr_width = $clog2(side*side)
) (
  input logic              clk,
  input logic              reset_n,
  pooling_unit_n_if.master bus
);
  localparam int ln = log2(n);
  localparam int aw = in_width + 2 * ln;
  localparam int iw = $clog2((side/n)**2);
  state_t               state_q, state_d;
  logic                 s_q, new_q, mode_q, done_q;
  logic                 last_in_window, last_window;
  logic [aw-1:0]        acc_q, acc_d, sample;
  logic [in_width-1:0]  res;
  logic [out_width-1:0] out_pixel_q;
  pool_window_addr_gen #(.n(n), .side(side), .addr_width(addr_width), .iw(iw)) u_gen (
    .clk              (clk),
    .reset_n          (reset_n),
    .step_i           (bus.en && state_q == FETCH),
    .next_i           (bus.en && state_q == EMIT && bus.out_ready),
    .in_addr_o        (bus.in_addr),
    .win_index_o      (bus.out_index),
    .last_in_window_o (last_in_window),
    .last_window_o    (last_window)
  );
  // s_q marks in_pixel as data for an address issued in FETCH last cycle;
  // new_q marks that the next flagged sample opens a window and replaces the accumulator.
  always_comb begin
    sample  = aw'(bus.in_pixel);
    acc_d   = !s_q ? acc_q : new_q ? sample : mode_q == MODE_MAX ? (sample > acc_q ? sample : acc_q) : acc_q + sample;
    res     = in_width'(mode_q == MODE_MAX ? acc_d : acc_d >> (2 * ln));
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.start ? FETCH : IDLE;
      FETCH:   state_d = last_in_window ? DRAIN : FETCH;
      DRAIN:   state_d = EMIT;
      EMIT:    state_d = !bus.out_ready ? EMIT : last_window ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // The last sample lands on the DRAIN edge, so the output register takes acc_d, not acc_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      new_q       <= 1'b1;
      mode_q      <= MODE_AVG;
      acc_q       <= '0;
      out_pixel_q <= '0;
      done_q      <= 1'b0;
    end else if (bus.en) begin
      state_q     <= state_d;
      s_q         <= state_q == FETCH;
      new_q       <= state_q == DRAIN || (new_q && !s_q);
      mode_q      <= state_q == IDLE && bus.start ? bus.mode : mode_q;
      acc_q       <= acc_d;
      out_pixel_q <= state_q == DRAIN ? res[in_width-1 -: out_width] : out_pixel_q;
      done_q      <= state_q == DONE;
    end
  end
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_valid = state_q == EMIT;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_pooling_unit_n.sv
// tb_pooling_unit_n: randomized self-checking bench for pooling_unit_n (side=8, n=2; out_width 8 and 4).
module tb_pooling_unit_n;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0, mode = 1'b0, out_ready = 1'b1;
  always #5 clk = ~clk;
  pooling_unit_n_if #(.in_width(8), .out_width(8), .n(2), .side(8)) bus_a ();
  pooling_unit_n_if #(.in_width(8), .out_width(4), .n(2), .side(8)) bus_b ();
  assign bus_a.en = en;
  assign bus_a.start = start;
  assign bus_a.mode = mode;
  assign bus_a.out_ready = out_ready;
  assign bus_b.en = en;
  assign bus_b.start = start;
  assign bus_b.mode = mode;
  assign bus_b.out_ready = out_ready;
  pooling_unit_n #(.in_width(8), .out_width(8), .n(2), .side(8)) dut_a (.clk(clk), .reset_n(rst_n), .bus(bus_a));
  pooling_unit_n #(.in_width(8), .out_width(4), .n(2), .side(8)) dut_b (.clk(clk), .reset_n(rst_n), .bus(bus_b));
  logic [7:0] mem [64];
  logic [7:0] pix_a, pix_b;
  always @(posedge clk) if (en) begin
    pix_a <= mem[bus_a.in_addr];
    pix_b <= mem[bus_b.in_addr];
  end
  assign bus_a.in_pixel = pix_a;
  assign bus_b.in_pixel = pix_b;
  int checks = 0, errors = 0;
  int qa_pix[$], qa_idx[$], qb_pix[$];
  int done_cyc, done_len, stall_seen, stall_viol, frz_seen, frz_viol;
  logic busy_at_done;
  logic hold = 1'b0, en_prev = 1'b1;
  logic [7:0] hold_pix;
  logic [3:0] hold_idx;
  logic [5:0] addr_prev;
  always @(negedge clk) if (rst_n) begin
    if (en && bus_a.out_valid && out_ready) begin
      qa_pix.push_back(int'(bus_a.out_pixel));
      qa_idx.push_back(int'(bus_a.out_index));
      qb_pix.push_back(int'(bus_b.out_pixel));
    end
    if (hold && bus_a.out_valid) begin
      stall_seen++;
      if (bus_a.out_pixel !== hold_pix || bus_a.out_index !== hold_idx) stall_viol++;
    end
    if (!en_prev) begin
      frz_seen++;
      if (bus_a.in_addr !== addr_prev) frz_viol++;
    end
    hold = bus_a.out_valid && !(out_ready && en);
    hold_pix = bus_a.out_pixel;
    hold_idx = bus_a.out_index;
    en_prev = en;
    addr_prev = bus_a.in_addr;
  end
  function automatic int ref_out(int k, bit m);
    int s = 0, mx = 0, p;
    for (int wy = 0; wy < 2; wy++)
      for (int wx = 0; wx < 2; wx++) begin
        p = mem[((k / 4) * 2 + wy) * 8 + (k % 4) * 2 + wx];
        s += p;
        if (p > mx) mx = p;
      end
    return m ? mx : s / 4;
  endfunction
  task automatic fill(int kind);
    for (int a = 0; a < 64; a++) mem[a] = kind == 0 ? 8'hFF : kind == 1 ? 8'(a) : 8'($urandom_range(0, 255));
  endtask
  // Runs one frame; mode is flipped right after start to show it is latched.
  task automatic run_frame(bit m, bit rnd, int stall_at, int stall_len, int dstall);
    int k;
    qa_pix.delete(); qa_idx.delete(); qb_pix.delete();
    done_cyc = 0; done_len = 0; busy_at_done = 1'bx;
    @(posedge clk); #1 start = 1'b1; mode = m; en = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0; mode = !m; k = 1;
    while (done_cyc == 0 && k < 3000) begin
      en = !(k >= stall_at && k < stall_at + stall_len);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus_a.done) begin
        done_cyc = k;
        busy_at_done = bus_a.busy;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (done_cyc != 0) begin
      #1 en = dstall == 0;
      for (int i = 0; i < 40 && bus_a.done; i++) begin
        done_len++;
        @(posedge clk); #1;
        if (i + 1 >= dstall) en = 1'b1;
        @(negedge clk);
      end
    end
    en = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus_a.in_addr !== 6'd0) begin errors++; $display("FAIL reset in_addr got %0h exp 0", bus_a.in_addr); end
    checks++; if (bus_a.out_pixel !== 8'd0 || bus_b.out_pixel !== 4'd0) begin errors++; $display("FAIL reset out_pixel got %0h/%0h exp 0", bus_a.out_pixel, bus_b.out_pixel); end
    checks++; if (bus_a.out_index !== 4'd0) begin errors++; $display("FAIL reset out_index got %0h exp 0", bus_a.out_index); end
    checks++; if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b/%b exp 0", bus_a.out_valid, bus_b.out_valid); end
    checks++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin errors++; $display("FAIL reset busy/done got %b/%b exp 0/0", bus_a.busy, bus_a.done); end
    @(posedge clk); #1 rst_n = 1'b1; en = 1'b1;
  endtask
  task automatic test_avg_ff();
    fill(0); run_frame(1'b0, 1'b0, 0, 0, 0);
    checks++; if (qa_pix.size() !== 16) begin errors++; $display("FAIL avg_ff count got %0d exp 16", qa_pix.size()); end
    for (int k = 0; k < qa_pix.size() && k < 16; k++) begin
      checks++;
      if (qa_pix[k] !== 255 || qa_idx[k] !== k || qb_pix[k] !== 15) begin
        errors++; $display("FAIL avg_ff out %0d got pix %0h idx %0d b %0h exp ff %0d f", k, qa_pix[k], qa_idx[k], qb_pix[k], k);
      end
    end
    checks++; if (done_cyc !== 98 || busy_at_done !== 1'b0 || done_len !== 1) begin
      errors++; $display("FAIL avg_ff done got cyc %0d busy %b len %0d exp 98 0 1", done_cyc, busy_at_done, done_len);
    end
  endtask
  task automatic test_ramp(bit m);
    fill(1); run_frame(m, 1'b0, 0, 0, 0);
    checks++; if (qa_pix.size() !== 16) begin errors++; $display("FAIL ramp_m%0d count got %0d exp 16", m, qa_pix.size()); end
    for (int k = 0; k < qa_pix.size() && k < 16; k++) begin
      checks++;
      if (qa_pix[k] !== ref_out(k, m) || qa_idx[k] !== k) begin
        errors++; $display("FAIL ramp_m%0d out %0d got %0h idx %0d exp %0h", m, k, qa_pix[k], qa_idx[k], ref_out(k, m));
      end
    end
    if (qa_pix.size() == 16) begin
      checks++; if (qa_pix[0] !== (m ? 9 : 4) || qa_pix[15] !== (m ? 63 : 58)) begin
        errors++; $display("FAIL ramp_m%0d ends got %0h %0h exp %0h %0h", m, qa_pix[0], qa_pix[15], m ? 9 : 4, m ? 63 : 58);
      end
    end
  endtask
  task automatic test_random_ready();
    bit m = 1'($urandom_range(0, 1));
    fill(2); stall_seen = 0; stall_viol = 0;
    run_frame(m, 1'b1, 0, 0, 0);
    checks++; if (qa_pix.size() !== 16) begin errors++; $display("FAIL rnd_ready count got %0d exp 16", qa_pix.size()); end
    for (int k = 0; k < qa_pix.size() && k < 16; k++) begin
      checks++;
      if (qa_pix[k] !== ref_out(k, m) || qa_idx[k] !== k || qb_pix[k] !== ref_out(k, m) / 16) begin
        errors++; $display("FAIL rnd_ready out %0d got %0h idx %0d b %0h exp %0h", k, qa_pix[k], qa_idx[k], qb_pix[k], ref_out(k, m));
      end
    end
    checks++; if (stall_seen == 0 || stall_viol !== 0) begin
      errors++; $display("FAIL rnd_ready stability got %0d unstable of %0d held exp 0 of >0", stall_viol, stall_seen);
    end
  endtask
  task automatic test_en_stall();
    fill(2); frz_seen = 0; frz_viol = 0;
    run_frame(1'b0, 1'b0, 3, 5, 5);
    checks++; if (qa_pix.size() !== 16) begin errors++; $display("FAIL en_stall count got %0d exp 16", qa_pix.size()); end
    for (int k = 0; k < qa_pix.size() && k < 16; k++) begin
      checks++;
      if (qa_pix[k] !== ref_out(k, 1'b0) || qa_idx[k] !== k) begin
        errors++; $display("FAIL en_stall out %0d got %0h idx %0d exp %0h", k, qa_pix[k], qa_idx[k], ref_out(k, 1'b0));
      end
    end
    checks++; if (frz_seen == 0 || frz_viol !== 0) begin errors++; $display("FAIL en_stall addr_freeze got %0d moves of %0d exp 0", frz_viol, frz_seen); end
    checks++; if (done_cyc !== 103 || done_len !== 6) begin errors++; $display("FAIL en_stall done got cyc %0d len %0d exp 103 6", done_cyc, done_len); end
  endtask
  task automatic test_abort();
    bit seen_done = 1'b0;
    fill(2);
    @(posedge clk); #1 start = 1'b1; mode = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 20 && !bus_a.out_valid; i++) @(negedge clk);
    checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL abort reach_emit got valid %b exp 1", bus_a.out_valid); end
    rst_n = 1'b0; #1;
    checks++; if (bus_a.busy !== 1'b0 || bus_a.out_valid !== 1'b0 || bus_b.busy !== 1'b0 || bus_b.out_valid !== 1'b0) begin
      errors++; $display("FAIL abort immediate got busy %b valid %b exp 0 0", bus_a.busy, bus_a.out_valid);
    end
    repeat (3) begin @(negedge clk); seen_done |= bus_a.done; end
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin @(negedge clk); seen_done |= bus_a.done | bus_b.done; end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort no_done got done %b exp 0", seen_done); end
    run_frame(1'b1, 1'b0, 0, 0, 0);
    checks++; if (qb_pix.size() !== 16) begin errors++; $display("FAIL abort_restart count got %0d exp 16", qb_pix.size()); end
    for (int k = 0; k < qb_pix.size() && k < 16; k++) begin
      checks++;
      if (qb_pix[k] !== ref_out(k, 1'b1) / 16 || qa_pix[k] !== ref_out(k, 1'b1)) begin
        errors++; $display("FAIL abort_restart out %0d got b %0h a %0h exp %0h %0h", k, qb_pix[k], qa_pix[k], ref_out(k, 1'b1) / 16, ref_out(k, 1'b1));
      end
    end
    checks++; if (done_cyc !== 98) begin errors++; $display("FAIL abort_restart done got %0d exp 98", done_cyc); end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_avg_ff();
    test_ramp(1'b0);
    test_ramp(1'b1);
    test_random_ready();
    test_en_stall();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
